// File: rtl/fan_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// fan_ctrl_pkg : PI engine state encoding, width helpers and saturation
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package fan_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_ERR  = 3'd1,
    ST_MUL  = 3'd2,
    ST_ACC  = 3'd3,
    ST_OUT  = 3'd4
  } state_t;

  // Width derivations shared by every user of the engine datapath.
  function automatic int e_w(input int adc_w);
    return adc_w + 1;
  endfunction

  function automatic int prod_w(input int coef_w, input int adc_w);
    return coef_w + adc_w + 1;
  endfunction

  function automatic int int_w(input int adc_w, input int frac_w);
    return adc_w + frac_w + 1;
  endfunction

  function automatic logic [31:0] sat_unsigned(input logic signed [31:0] v,
                                               input logic [31:0]        max_v);
    if (v < 0) return '0;
    if (v > $signed(max_v)) return max_v;
    return v;
  endfunction

endpackage

`default_nettype wire

// File: rtl/fan_pwm_gen.sv
// ---------------------------------------------------------------------------
// fan_pwm_gen : shared period counter with per-channel shadow/active duties
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module fan_pwm_gen #(
  parameter int N_CH  = 4,
  parameter int PWM_W = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clk_en,
  input  logic [PWM_W-1:0]      period,
  input  logic [N_CH-1:0]       ch_enable,
  input  logic [N_CH-1:0]       wr_sel,
  input  logic [PWM_W-1:0]      wr_duty,
  output logic [N_CH-1:0]       pwm,
  output logic [N_CH*PWM_W-1:0] duty
);

  logic [PWM_W-1:0] cnt;
  logic [PWM_W-1:0] shadow [N_CH];
  logic [PWM_W-1:0] active [N_CH];
  logic             wrap;

  // >= rather than == so a period shrunk below cnt wraps at once.
  assign wrap = clk_en && (cnt >= period);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clk_en) begin
      cnt <= wrap ? '0 : cnt + PWM_W'(1);
    end
  end

  // active only ever changes at a wrap, so each period sees one duty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < N_CH; c++) begin
        shadow[c] <= '0;
        active[c] <= '0;
      end
      pwm <= '0;
    end else begin
      for (int c = 0; c < N_CH; c++) begin
        if (!ch_enable[c]) begin
          shadow[c] <= '0;
          active[c] <= '0;
        end else begin
          if (wr_sel[c]) shadow[c] <= wr_duty;
          if (wrap)      active[c] <= shadow[c];
        end
        pwm[c] <= ch_enable[c] && (cnt < active[c]);
      end
    end
  end

  for (genvar c = 0; c < N_CH; c++) begin : g_duty
    assign duty[c*PWM_W +: PWM_W] = active[c];
  end

endmodule

`default_nettype wire

// File: rtl/fan_ctrl_mc.sv
// ---------------------------------------------------------------------------
// fan_ctrl_mc : time-multiplexed PI engine driving N_CH PWM fan outputs
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module fan_ctrl_mc
  import fan_ctrl_pkg::*;
#(
  parameter int N_CH   = 4,
  parameter int CH_W   = 2,
  parameter int ADC_W  = 4,
  parameter int FRAC_W = 6,
  parameter int COEF_W = 10,
  parameter int PWM_W  = 5
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic                  clk_en_i,
  input  logic                  sample_valid_i,
  output logic                  sample_ready_o,
  input  logic [CH_W-1:0]       sample_ch_i,
  input  logic [ADC_W-1:0]      adc_value_i,
  input  logic [ADC_W-1:0]      set_value_i,
  input  logic [COEF_W-1:0]     kp_i,
  input  logic [COEF_W-1:0]     ki_i,
  input  logic [PWM_W-1:0]      pwm_period_i,
  input  logic [PWM_W-1:0]      pwm_min_i,
  input  logic [N_CH-1:0]       ch_enable_i,
  output logic [N_CH-1:0]       pwm_o,
  output logic [N_CH*PWM_W-1:0] duty_o,
  output logic                  busy_o
);

  localparam int E_W    = e_w(ADC_W);
  localparam int PROD_W = prod_w(COEF_W, ADC_W);
  localparam int INT_W  = int_w(ADC_W, FRAC_W);
  localparam int SUM_W  = PROD_W + 2;
  localparam logic [31:0]    IMAX     = ((32'd1 << ADC_W) - 32'd1) << FRAC_W;
  localparam logic [31:0]    UMAX     = (32'd1 << ADC_W) - 32'd1;
  localparam logic [PWM_W:0] DUTY_MAX = (PWM_W+1)'((1 << PWM_W) - 1);

  state_t                   state, state_nxt;
  logic [CH_W-1:0]          ch_q;
  logic [ADC_W-1:0]         adc_q, set_q;
  logic signed [COEF_W-1:0] kp_q, ki_q;
  logic signed [E_W-1:0]    err_q;
  logic signed [PROD_W-1:0] p_q, di_q;
  logic [INT_W-1:0]         integ_rd_q, integ_new_q;
  logic signed [SUM_W-1:0]  sum_q;
  logic [INT_W-1:0]         integ [N_CH];

  logic                     accept, ch_ok, wr_en;
  logic [INT_W-1:0]         integ_sat;
  logic [ADC_W-1:0]         u_val;
  logic [PWM_W:0]           duty_sum, period_p1, duty_lim;
  logic [PWM_W-1:0]         duty_new;
  logic [N_CH-1:0]          wr_sel;

  assign sample_ready_o = (state == ST_IDLE);
  assign busy_o         = !sample_ready_o;
  assign accept         = sample_ready_o && sample_valid_i;
  assign ch_ok          = (32'(ch_q) < N_CH);

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) state <= ST_IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (sample_valid_i) state_nxt = ST_ERR;
      ST_ERR:  state_nxt = ST_MUL;
      ST_MUL:  state_nxt = ST_ACC;
      ST_ACC:  state_nxt = ST_OUT;
      ST_OUT:  state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Anti-windup: the integrator never leaves [0, IMAX].
  assign integ_sat = INT_W'(sat_unsigned(32'($signed({1'b0, integ_rd_q})) + 32'(di_q), IMAX));

  // Arithmetic shift floors toward -inf before the output clamp.
  assign u_val     = ADC_W'(sat_unsigned(32'(sum_q >>> FRAC_W), UMAX));
  assign duty_sum  = {1'b0, pwm_min_i} + (PWM_W+1)'(u_val);
  assign period_p1 = {1'b0, pwm_period_i} + (PWM_W+1)'(1);
  assign duty_lim  = (duty_sum < period_p1) ? duty_sum : period_p1;
  assign duty_new  = (u_val == '0)          ? '0 :
                     (duty_lim > DUTY_MAX)  ? '1 : duty_lim[PWM_W-1:0];

  assign wr_en = (state == ST_OUT) && ch_ok && ch_enable_i[ch_q];

  always_comb begin
    wr_sel = '0;
    for (int c = 0; c < N_CH; c++) begin
      if (wr_en && (32'(ch_q) == c)) wr_sel[c] = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      ch_q        <= '0;
      adc_q       <= '0;
      set_q       <= '0;
      kp_q        <= '0;
      ki_q        <= '0;
      err_q       <= '0;
      p_q         <= '0;
      di_q        <= '0;
      integ_rd_q  <= '0;
      integ_new_q <= '0;
      sum_q       <= '0;
    end else begin
      case (state)
        ST_IDLE: if (accept) begin
          ch_q  <= sample_ch_i;
          adc_q <= adc_value_i;
          set_q <= set_value_i;
          kp_q  <= kp_i;
          ki_q  <= ki_i;
        end
        ST_ERR: begin
          err_q      <= $signed({1'b0, set_q}) - $signed({1'b0, adc_q});
          integ_rd_q <= ch_ok ? integ[ch_q] : '0;
        end
        ST_MUL: begin
          p_q  <= PROD_W'(kp_q) * PROD_W'(err_q);
          di_q <= PROD_W'(ki_q) * PROD_W'(err_q);
        end
        ST_ACC: begin
          integ_new_q <= integ_sat;
          sum_q       <= SUM_W'(p_q) + SUM_W'($signed({1'b0, integ_sat}));
        end
        default: ;
      endcase
    end
  end

  // A disabled channel restarts from an empty integrator when re-enabled.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      for (int c = 0; c < N_CH; c++) integ[c] <= '0;
    end else begin
      for (int c = 0; c < N_CH; c++) begin
        if (!ch_enable_i[c])  integ[c] <= '0;
        else if (wr_sel[c])   integ[c] <= integ_new_q;
      end
    end
  end

  fan_pwm_gen #(
    .N_CH  (N_CH),
    .PWM_W (PWM_W)
  ) u_pwm (
    .clk       (clk_i),
    .rst_n     (rstn_i),
    .clk_en    (clk_en_i),
    .period    (pwm_period_i),
    .ch_enable (ch_enable_i),
    .wr_sel    (wr_sel),
    .wr_duty   (duty_new),
    .pwm       (pwm_o),
    .duty      (duty_o)
  );

endmodule

`default_nettype wire

// File: tb/tb_fan_ctrl_mc.sv
// ---------------------------------------------------------------------------
// tb_fan_ctrl_mc : directed scoreboard bench for the multi-channel fan controller
// Rev 1.0
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_fan_ctrl_mc;

  localparam int N_CH   = 4;
  localparam int CH_W   = 2;
  localparam int ADC_W  = 4;
  localparam int COEF_W = 10;
  localparam int PWM_W  = 5;
  localparam int PERIOD = 19;
  localparam int PMIN   = 3;
  localparam int IMAX   = 960;
  localparam int VW     = N_CH * PWM_W;

  logic                  clk_i = 1'b0;
  logic                  rstn_i;
  logic                  clk_en_i;
  logic                  sample_valid_i;
  logic                  sample_ready_o;
  logic [CH_W-1:0]       sample_ch_i;
  logic [ADC_W-1:0]      adc_value_i;
  logic [ADC_W-1:0]      set_value_i;
  logic [COEF_W-1:0]     kp_i;
  logic [COEF_W-1:0]     ki_i;
  logic [PWM_W-1:0]      pwm_period_i;
  logic [PWM_W-1:0]      pwm_min_i;
  logic [N_CH-1:0]       ch_enable_i;
  logic [N_CH-1:0]       pwm_o;
  logic [VW-1:0]         duty_o;
  logic                  busy_o;

  fan_ctrl_mc #(
    .N_CH(N_CH), .CH_W(CH_W), .ADC_W(ADC_W), .FRAC_W(6), .COEF_W(COEF_W), .PWM_W(PWM_W)
  ) dut (
    .clk_i          (clk_i),
    .rstn_i         (rstn_i),
    .clk_en_i       (clk_en_i),
    .sample_valid_i (sample_valid_i),
    .sample_ready_o (sample_ready_o),
    .sample_ch_i    (sample_ch_i),
    .adc_value_i    (adc_value_i),
    .set_value_i    (set_value_i),
    .kp_i           (kp_i),
    .ki_i           (ki_i),
    .pwm_period_i   (pwm_period_i),
    .pwm_min_i      (pwm_min_i),
    .ch_enable_i    (ch_enable_i),
    .pwm_o          (pwm_o),
    .duty_o         (duty_o),
    .busy_o         (busy_o)
  );

  always #50 clk_i = ~clk_i;

  int            checks = 0;
  int            errors = 0;
  int            m_integ  [N_CH];
  int            m_shadow [N_CH];
  int            m_cnt;
  logic [VW-1:0] sb_q [$];
  logic [VW-1:0] pre;
  int            guard, last, n_acc, n_busy;

  // Reference period counter; period and clk_en are held constant.
  always @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i)       m_cnt <= 0;
    else if (clk_en_i) m_cnt <= (m_cnt >= PERIOD) ? 0 : m_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    for (int c = 0; c < N_CH; c++) begin
      m_integ[c]  = 0;
      m_shadow[c] = 0;
    end
  endfunction

  function automatic void model_sample(input int ch, input int set, input int adc,
                                       input int kp, input int ki);
    int e, p, ni, s, u, d;
    e  = set - adc;
    p  = kp * e;
    ni = ((ch < N_CH) ? m_integ[ch] : 0) + ki * e;
    if (ni < 0)    ni = 0;
    if (ni > IMAX) ni = IMAX;
    s = p + ni;
    u = s >>> 6;
    if (u < 0)  u = 0;
    if (u > 15) u = 15;
    d = (u == 0) ? 0 : PMIN + u;
    if (d > PERIOD + 1) d = PERIOD + 1;
    if (d > 31)         d = 31;
    if (ch < N_CH && ch_enable_i[ch] === 1'b1) begin
      m_integ[ch]  = ni;
      m_shadow[ch] = d;
    end
  endfunction

  function automatic logic [VW-1:0] expected_duties();
    logic [VW-1:0] v;
    v = '0;
    for (int c = 0; c < N_CH; c++) v[c*PWM_W +: PWM_W] = PWM_W'(m_shadow[c]);
    return v;
  endfunction

  task automatic set_enable(input logic [N_CH-1:0] en);
    ch_enable_i = en;
    for (int c = 0; c < N_CH; c++) begin
      if (!en[c]) begin
        m_integ[c]  = 0;
        m_shadow[c] = 0;
      end
    end
  endtask

  task automatic wait_n(input int n);
    repeat (n) @(negedge clk_i);
  endtask

  task automatic drive(input int ch, input int set, input int adc, input int kp, input int ki);
    sample_ch_i = CH_W'(ch);
    set_value_i = ADC_W'(set);
    adc_value_i = ADC_W'(adc);
    kp_i        = COEF_W'(kp);
    ki_i        = COEF_W'(ki);
  endtask

  task automatic send(input int ch, input int set, input int adc, input int kp, input int ki);
    int g;
    g = 0;
    @(negedge clk_i);
    while (sample_ready_o !== 1'b1 && g < 20) begin
      @(negedge clk_i);
      g++;
    end
    check("send_ready", 32'(sample_ready_o), 32'd1);
    drive(ch, set, adc, kp, ki);
    sample_valid_i = 1'b1;
    @(posedge clk_i);
    #1;
    sample_valid_i = 1'b0;
    model_sample(ch, set, adc, kp, ki);
    sb_q.push_back(expected_duties());
  endtask

  task automatic check_sb(input string tag);
    logic [VW-1:0] exp;
    if (sb_q.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s: observed empty scoreboard expected an entry", tag);
    end else begin
      while (sb_q.size() > 1) void'(sb_q.pop_front());
      exp = sb_q.pop_front();
      check(tag, 32'(duty_o), 32'(exp));
    end
  endtask

  task automatic count_high(input int ch, output int n);
    n = 0;
    repeat (20) begin
      @(negedge clk_i);
      if (pwm_o[ch] === 1'b1) n++;
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    rstn_i         = 1'b0;
    clk_en_i       = 1'b1;
    sample_valid_i = 1'b0;
    drive(0, 0, 0, 0, 0);
    pwm_period_i   = PWM_W'(PERIOD);
    pwm_min_i      = PWM_W'(PMIN);
    ch_enable_i    = '1;
    model_reset();

    wait_n(3);
    check("reset_ready", 32'(sample_ready_o), 32'd1);
    check("reset_busy",  32'(busy_o),         32'd0);
    check("reset_duty",  32'(duty_o),         32'd0);
    check("reset_pwm",   32'(pwm_o),          32'd0);
    rstn_i = 1'b1;

    send(1, 10, 4, 64, 16);
    wait_n(45);
    check_sb("ch1_first");
    check("ch1_duty10", 32'(duty_o[PWM_W +: PWM_W]), 32'd10);
    count_high(1, n);
    check("ch1_pwm_high10", 32'(n), 32'd10);

    send(1, 10, 4, 64, 16);
    wait_n(45);
    check_sb("ch1_second");
    check("ch1_duty12", 32'(duty_o[PWM_W +: PWM_W]), 32'd12);

    repeat (3) send(2, 15, 0, 0, 64);
    wait_n(45);
    check_sb("ch2_clamp");
    check("ch2_duty18", 32'(duty_o[2*PWM_W +: PWM_W]), 32'd18);

    send(2, 3, 4, 0, 64);
    wait_n(45);
    check_sb("ch2_unwind");
    check("ch2_duty17", 32'(duty_o[2*PWM_W +: PWM_W]), 32'd17);

    send(0, 0, 15, 64, 16);
    wait_n(45);
    check_sb("ch0_negative");
    count_high(0, n);
    check("ch0_pwm_low", 32'(n), 32'd0);

    // Integrator held at 0 above, so e=1 with ki=64 gives u=1, duty 4.
    send(0, 5, 4, 0, 64);
    wait_n(45);
    check_sb("ch0_lower_clamp");
    check("ch0_duty4", 32'(duty_o[0 +: PWM_W]), 32'd4);

    // Valid held high: accepts must be exactly 5 cycles apart.
    @(negedge clk_i);
    drive(1, 10, 4, 64, 16);
    sample_valid_i = 1'b1;
    last   = -1;
    n_acc  = 0;
    n_busy = 0;
    for (int i = 0; i < 15; i++) begin
      if (sample_ready_o === 1'b1) begin
        if (last >= 0) check("accept_spacing", 32'(i - last), 32'd5);
        last = i;
        n_acc++;
        model_sample(1, 10, 4, 64, 16);
        sb_q.push_back(expected_duties());
      end else if (busy_o === 1'b1) begin
        n_busy++;
      end
      @(negedge clk_i);
    end
    sample_valid_i = 1'b0;
    check("accept_count", 32'(n_acc),  32'd3);
    check("busy_cycles",  32'(n_busy), 32'd12);
    wait_n(45);
    check_sb("b2b_result");

    // Land the OUT write on the wrap cycle: cnt=15 at accept -> 19 at OUT.
    guard = 0;
    @(negedge clk_i);
    while (!(m_cnt == 15 && sample_ready_o === 1'b1) && guard < 100) begin
      @(negedge clk_i);
      guard++;
    end
    check("wrap_align_in_time", 32'(guard < 100), 32'd1);
    pre = expected_duties();
    drive(3, 8, 0, 64, 0);
    sample_valid_i = 1'b1;
    @(posedge clk_i);
    #1;
    sample_valid_i = 1'b0;
    wait_n(5);
    check("wrap_same_cycle_old", 32'(duty_o), 32'(pre));
    model_sample(3, 8, 0, 64, 0);
    sb_q.push_back(expected_duties());
    wait_n(20);
    check_sb("wrap_next_period");
    check("ch3_duty11", 32'(duty_o[3*PWM_W +: PWM_W]), 32'd11);

    // Reset during MUL.
    @(negedge clk_i);
    drive(1, 10, 4, 64, 16);
    sample_valid_i = 1'b1;
    @(posedge clk_i);
    #1;
    sample_valid_i = 1'b0;
    wait_n(2);
    rstn_i = 1'b0;
    #1;
    check("midrst_ready", 32'(sample_ready_o), 32'd1);
    check("midrst_busy",  32'(busy_o),         32'd0);
    check("midrst_duty",  32'(duty_o),         32'd0);
    check("midrst_pwm",   32'(pwm_o),          32'd0);
    model_reset();
    sb_q.delete();
    @(negedge clk_i);
    rstn_i = 1'b1;

    send(1, 10, 4, 64, 16);
    wait_n(45);
    check_sb("fresh_after_reset");
    check("fresh_duty10", 32'(duty_o[PWM_W +: PWM_W]), 32'd10);

    send(3, 8, 0, 64, 0);
    wait_n(45);
    check_sb("ch3_enabled");

    set_enable(4'b0111);
    send(3, 8, 0, 64, 0);
    wait_n(45);
    check_sb("ch3_disabled");
    check("ch3_duty0", 32'(duty_o[3*PWM_W +: PWM_W]), 32'd0);
    count_high(3, n);
    check("ch3_pwm_low", 32'(n), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/fan_ctrl_mc.md
Name: fan_ctrl_mc

Overview:
- Multi-channel successor of the single-fan PI controller.
- One time-multiplexed PI engine serves N_CH fans. It takes (ADC, setpoint) samples tagged with a channel over a valid/ready handshake and keeps a per-channel integrator with anti-windup clamp.
- Drives N_CH glitch-free PWM outputs from one shared period counter, with minimum-speed offset and per-channel enable.
- Sits between the ADC/strobe front end and the fan pins at top level.

Parameters:
- N_CH, 4, number of fan channels (>=1)
- CH_W, 2, channel index width (clog2(N_CH), min 1)
- ADC_W, 4, ADC/setpoint width (unsigned)
- FRAC_W, 6, fractional bits of kp/ki and integrator
- COEF_W, 10, signed coefficient width
- PWM_W, 5, PWM counter/duty width

Ports:
- clk_i  in  1  clock (10 MHz)
- rstn_i  in  1  reset, asynchronous, active-low
- clk_en_i  in  1  PWM counter advance enable
- sample_valid_i  in  1  sample strobe
- sample_ready_o  out  1  engine idle, can accept a sample
- sample_ch_i  in  CH_W  target channel
- adc_value_i  in  ADC_W  measured value
- set_value_i  in  ADC_W  setpoint
- kp_i  in  COEF_W  signed proportional gain, Q.FRAC_W
- ki_i  in  COEF_W  signed integral gain, Q.FRAC_W
- pwm_period_i  in  PWM_W  last counter value of a PWM period
- pwm_min_i  in  PWM_W  duty offset for any nonzero output
- ch_enable_i  in  N_CH  per-channel enable
- pwm_o  out  N_CH  PWM outputs
- duty_o  out  N_CH*PWM_W  active duty per channel, channel c at [c*PWM_W +: PWM_W]
- busy_o  out  1  engine not idle

Behaviour:
- Single clock. Reset is asynchronous and active-low.
- Reset values: all outputs 0 except sample_ready_o=1. Integrators, shadow/active duties and PWM counter are 0. FSM is in IDLE.
- FSM states: IDLE -> ERR -> MUL -> ACC -> OUT -> IDLE, advancing every clk (not gated by clk_en_i).
- Accept: sample_valid_i & sample_ready_o in IDLE. The inputs (ch, adc, set, kp, ki) are latched at accept.
- sample_ready_o = (state==IDLE); busy_o = !ready. Valid while busy is ignored, not queued.
- ERR: e = set - adc, signed ADC_W+1. Reads integ[ch].
- MUL: p = kp*e, di = ki*e, signed COEF_W+ADC_W+1.
- ACC: integ' = clamp(integ+di, 0, IMAX), where IMAX = (2^ADC_W-1)<<FRAC_W. This is the anti-windup. s = p + integ'.
- OUT: u = clamp(s >>> FRAC_W, 0, 2^ADC_W-1), using an arithmetic (floor) shift.
- OUT: shadow[ch] = (u==0) ? 0 : min(pwm_min + u, pwm_period+1). integ[ch] <- integ'.
- Latency: accept at cycle T, so shadow and integ are written at the end of T+4. Throughput is 1 sample per 5 cycles.
- sample_ch_i >= N_CH: the sample is accepted and runs through the FSM, but no state is written.
- PWM counter: on clk_en_i, cnt <= (cnt >= pwm_period_i) ? 0 : cnt+1. A shrinking period therefore wraps immediately.
- Period-boundary load: on a clk_en_i cycle where cnt wraps to 0, active[c] <= shadow[c] for all c. duty_o reflects active.
- If the OUT write and the wrap fall in the same cycle, active loads the old shadow and the new value applies at the next wrap.
- pwm_o[c] = ch_enable_i[c] & (cnt < active[c]), registered. Duty 0 means output never high. Duty > period means output always high.
- ch_enable_i[c]=0: integ[c] is held at 0 (cleared each cycle), shadow[c] and active[c] are forced to 0, and samples for c are still accepted but write nothing.
- Reset asserted mid-calculation aborts the calculation. No partial write survives.

Decomposition:
- fan_ctrl_pkg holds:
  - the FSM state enum (IDLE, ERR, MUL, ACC, OUT);
  - the sat_unsigned helper function;
  - localparam width derivations (E_W, PROD_W, INT_W = ADC_W+FRAC_W+1).
- One sub-module, fan_pwm_gen: shared period counter, per-channel shadow/active registers and comparators, parametrised by N_CH and PWM_W.
- The PI FSM and the integrator array stay in fan_ctrl_mc.

Test Plan:
- Default params, kp=64, ki=16, pwm_min=3, period=19, ch1 set=10 adc=4 -> e=6, integ=96, s=480, u=7, shadow[1]=10 at T+4. At the next wrap pwm_o[1] is high for 10 of 20 clk_en cycles.
- Repeat the same sample on ch1 -> integ=192, u=9, duty_o[1]=12. Other channels unchanged (0).
- kp=0, ki=64, ch2 e=15 three times -> integ clamps at 960, u=15, duty=18. Then e=-1 -> integ=896, u=14, duty=17.
- ch0 set=0 adc=15, kp=64 -> s<0, u=0, duty 0, pwm_o[0] stays low. Integ stays 0 (lower clamp).
- Valid held high continuously -> accepts spaced exactly 5 cycles, busy_o high for 4 cycles after each accept. A write coinciding with a wrap takes effect one period later.
- Assert rstn_i low during MUL -> all outputs 0 asynchronously, ready=1. After release an identical sample yields a result as from a fresh state. ch_enable_i[3]=0 with a sample to ch3 leaves duty 0.
